// File: rtl/aes_pkg.sv
// Shared AES definitions: round-sequencer state encoding, AES-128 constants and the GF(2^8) xtime helper.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} round_state_t;

    localparam int unsigned AES128_NR = 10;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Rcon byte register: synchronous clear to RCON_INIT, advance by xtime when enabled.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       clear_i,
    input  logic       adv_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (clear_i) begin
            rcon_d = RCON_INIT;
        end else if (adv_i) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk) begin
        rcon_q <= rcon_d;
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encrypt round sequencer: IDLE -> INIT -> ROUND(1..NR, CPR cycles each) -> DONE.
// Optional abort input/aborted pulse when AES_ROUND_ABORT_EN is defined.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR  = AES128_NR,
    parameter int unsigned CPR = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef AES_ROUND_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       load_state,
    output logic       round_en,
    output logic       key_step,
    output logic [3:0] round,
    output logic       last_rnd,
    output logic [7:0] rcon
);

    localparam int unsigned RW = 4;
    localparam logic [RW-1:0] NR_W      = RW'(NR);
    localparam logic [RW-1:0] SUB_LAST  = RW'(CPR - 1);
    localparam logic          CPR_ONE   = 1'(CPR == 1);
    localparam logic          NR_ONE    = 1'(NR == 1);

    round_state_t  state_q;
    logic [RW-1:0] round_q;
    logic [RW-1:0] sub_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          load_q;
    logic          round_en_q;
    logic          last_q;

    logic          last_sub;
    logic          abort_hit;
    logic          rcon_clr;
    logic          rcon_adv;

    assign last_sub = (sub_q == SUB_LAST);

`ifdef AES_ROUND_ABORT_EN
    logic aborted_q;

    // Abort only acts in INIT/ROUND; a DONE cycle always completes
    assign abort_hit = abort && ((state_q == INIT) || (state_q == ROUND));

    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_hit;
        end
    end

    assign aborted = aborted_q;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || abort_hit) begin
            state_q    <= IDLE;
            round_q    <= '0;
            sub_q      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_q     <= 1'b0;
            round_en_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            load_q     <= 1'b0;
            round_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= INIT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        load_q  <= 1'b1;
                    end
                end
                INIT: begin
                    state_q    <= ROUND;
                    round_q    <= RW'(1);
                    sub_q      <= '0;
                    round_en_q <= CPR_ONE;
                    last_q     <= NR_ONE;
                end
                ROUND: begin
                    if (last_sub) begin
                        if (round_q < NR_W) begin
                            round_q    <= round_q + RW'(1);
                            sub_q      <= '0;
                            round_en_q <= CPR_ONE;
                            last_q     <= ((round_q + RW'(1)) == NR_W);
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            last_q  <= 1'b0;
                        end
                    end else begin
                        sub_q      <= sub_q + RW'(1);
                        round_en_q <= ((sub_q + RW'(1)) == SUB_LAST);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    round_q <= '0;
                    sub_q   <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Rcon restarts at 01 for round 1 and after every block; steps only between rounds
    assign rcon_clr = reset || abort_hit || (state_q == INIT) || (state_q == DONE);
    assign rcon_adv = (state_q == ROUND) && last_sub && (round_q < NR_W);

    aes_rcon_gen u_rcon (
        .clk     (clk),
        .clear_i (rcon_clr),
        .adv_i   (rcon_adv),
        .rcon_o  (rcon)
    );

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_state = load_q;
    assign round_en   = round_en_q;
    assign key_step   = round_en_q;
    assign round      = round_q;
    assign last_rnd   = last_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: one CPR=1 instance and one CPR=4 instance, hand-computed expectations.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start4 = 1'b0;

    logic       ready, busy, done, load_state, round_en, key_step, last_rnd;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       ready4, busy4, done4, load4, round_en4, key_step4, last4;
    logic [3:0] round4;
    logic [7:0] rcon4;
`ifdef AES_ROUND_ABORT_EN
    logic abort = 1'b0;
    logic abort4 = 1'b0;
    logic aborted, aborted4;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] rc_tab [10];
    logic       seen_done;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .CPR(1)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef AES_ROUND_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .ready(ready), .busy(busy), .done(done), .load_state(load_state),
        .round_en(round_en), .key_step(key_step), .round(round),
        .last_rnd(last_rnd), .rcon(rcon)
    );

    aes_round_ctrl #(.NR(10), .CPR(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
`ifdef AES_ROUND_ABORT_EN
        .abort(abort4), .aborted(aborted4),
`endif
        .ready(ready4), .busy(busy4), .done(done4), .load_state(load4),
        .round_en(round_en4), .key_step(key_step4), .round(round4),
        .last_rnd(last4), .rcon(rcon4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rc_tab[0] = 8'h01; rc_tab[1] = 8'h02; rc_tab[2] = 8'h04; rc_tab[3] = 8'h08;
        rc_tab[4] = 8'h10; rc_tab[5] = 8'h20; rc_tab[6] = 8'h40; rc_tab[7] = 8'h80;
        rc_tab[8] = 8'h1B; rc_tab[9] = 8'h36;

        // Reset state
        tick(); tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_round", 32'(round), 32'd0);
        chk("rst_rcon", 32'(rcon), 32'h01);
        chk("rst_pulses", 32'({done, load_state, round_en, key_step, last_rnd}), 32'd0);
        chk("rst_ready4", 32'(ready4), 32'd1);
        reset = 1'b0;
        tick();
        chk("idle_ready", 32'(ready), 32'd1);

        // CPR=1 block, start pulse in cycle T
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init_load", 32'(load_state), 32'd1);
        chk("init_round", 32'(round), 32'd0);
        chk("init_busy", 32'({ready, busy}), 32'b01);
        chk("init_round_en", 32'(round_en), 32'd0);
        for (int k = 2; k <= 11; k++) begin
            tick();
            chk("r_round", 32'(round), 32'(k - 1));
            chk("r_rcon", 32'(rcon), 32'(rc_tab[k - 2]));
            chk("r_round_en", 32'({round_en, key_step}), 32'b11);
            chk("r_last", 32'(last_rnd), 32'(k == 11));
            chk("r_done", 32'(done), 32'd0);
            chk("r_load", 32'(load_state), 32'd0);
            if (k == 5) start = 1'b1;
            else if (k == 6) start = 1'b0;
        end
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_ready", 32'({ready, busy}), 32'b01);
        chk("done_round", 32'(round), 32'd10);
        chk("done_last", 32'(last_rnd), 32'd0);
        chk("done_round_en", 32'(round_en), 32'd0);
        start = 1'b1;
        tick();
        chk("post_done", 32'(done), 32'd0);
        chk("post_ready", 32'({ready, busy}), 32'b10);
        chk("post_round", 32'(round), 32'd0);
        chk("post_rcon", 32'(rcon), 32'h01);
        chk("post_load", 32'(load_state), 32'd0);
        tick();
        start = 1'b0;
        chk("reinit_load", 32'(load_state), 32'd1);
        chk("reinit_busy", 32'(busy), 32'd1);

        // Reset while round=5
        repeat (5) tick();
        chk("pre_rst_round", 32'(round), 32'd5);
        chk("pre_rst_rcon", 32'(rcon), 32'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_round", 32'(round), 32'd0);
        chk("midrst_rcon", 32'(rcon), 32'h01);
        chk("midrst_ready", 32'({ready, busy}), 32'b10);
        chk("midrst_pulses", 32'({done, round_en, last_rnd}), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("midrst_no_done", 32'(seen_done), 32'd0);
        chk("midrst_idle", 32'(ready), 32'd1);

        // CPR=4 block
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("c4_load", 32'(load4), 32'd1);
        for (int k = 2; k <= 41; k++) begin
            tick();
            chk("c4_round", 32'(round4), 32'((k - 2) / 4 + 1));
            chk("c4_round_en", 32'({round_en4, key_step4}), ((k - 2) % 4 == 3) ? 32'b11 : 32'b00);
            chk("c4_rcon", 32'(rcon4), 32'(rc_tab[(k - 2) / 4]));
            chk("c4_done", 32'(done4), 32'd0);
        end
        tick();
        chk("c4_done_pulse", 32'(done4), 32'd1);
        chk("c4_done_round", 32'(round4), 32'd10);
        tick();
        chk("c4_idle", 32'({ready4, done4}), 32'b10);

`ifdef AES_ROUND_ABORT_EN
        // Abort at round 3
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("ab_round", 32'(round), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_pulse", 32'(aborted), 32'd1);
        chk("ab_ready", 32'({ready, busy}), 32'b10);
        chk("ab_state", 32'({round, rcon}), 32'h001);
        chk("ab_done", 32'(done), 32'd0);
        tick();
        chk("ab_pulse_end", 32'(aborted), 32'd0);
        // Abort during DONE is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        chk("abd_done", 32'(done), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abd_aborted", 32'(aborted), 32'd0);
        chk("abd_ready", 32'(ready), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
